// File: rtl/usart_tx_serializer.sv
// USART transmit serializer: pops characters from a show-ahead TX FIFO and
// shifts out async frames (start, 5-9 data LSB first, optional parity,
// 1-2 stop bits). Bit timing comes only from the external tx_tick strobe.
module usart_tx_serializer #(
  parameter int DATA_W = 9
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic              tx_tick,
  input  logic              txen,
  input  logic [2:0]        ucsz,
  input  logic [1:0]        upm,
  input  logic              usbs,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_re,
  output logic              txd,
  output logic              txc_set,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t              state_q, state_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                txc_set_q, txc_set_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    size_q, size_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                two_stop_q, two_stop_d;

  logic [CNT_W-1:0]    size_in;
  logic                par_calc;
  logic                par_bit_in;
  logic                frame_end;
  logic                load;

  // Character size decode; reserved encodings fall back to 8 bits.
  function automatic logic [CNT_W-1:0] char_size(input logic [2:0] c);
    case (c)
      3'b000:  return CNT_W'(5);
      3'b001:  return CNT_W'(6);
      3'b010:  return CNT_W'(7);
      3'b111:  return CNT_W'(9);
      default: return CNT_W'(8);
    endcase
  endfunction

  // Parity over the live config and FIFO head, captured once at load so the
  // frame never depends on config or FIFO contents after the pop.
  always_comb begin
    size_in  = char_size(ucsz);
    par_calc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(size_in)) par_calc = par_calc ^ fifo_dout[i];
    end
    par_bit_in = upm[0] ? ~par_calc : par_calc;
  end

  // Frame sequencing: next-state, next-bit and the load/end decisions.
  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    txc_set_d  = 1'b0;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;

    frame_end = tx_tick && (((state_q == S_STOP1) && !two_stop_q) ||
                            (state_q == S_STOP2));
    // Load from idle, or straight after the last stop bit (no idle gap).
    load = tx_tick && txen && !fifo_empty &&
           ((state_q == S_IDLE) || frame_end);

    if (load) begin
      sh_d       = fifo_dout;
      size_d     = size_in;
      par_en_d   = upm[1];
      par_bit_d  = par_bit_in;
      two_stop_d = usbs;
      cnt_d      = '0;
      txd_d      = 1'b0;
      busy_d     = 1'b1;
      state_d    = S_START;
    end else if (frame_end) begin
      txd_d     = 1'b1;
      busy_d    = 1'b0;
      txc_set_d = 1'b1;
      state_d   = S_IDLE;
    end else if (tx_tick) begin
      case (state_q)
        S_START: begin
          txd_d   = sh_q[0];
          sh_d    = {1'b0, sh_q[DATA_W-1:1]};
          cnt_d   = CNT_W'(1);
          state_d = S_DATA;
        end
        S_DATA: begin
          if (cnt_q < size_q) begin
            txd_d = sh_q[0];
            sh_d  = {1'b0, sh_q[DATA_W-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
          end else if (par_en_q) begin
            txd_d   = par_bit_q;
            state_d = S_PARITY;
          end else begin
            txd_d   = 1'b1;
            state_d = S_STOP1;
          end
        end
        S_PARITY: begin
          txd_d   = 1'b1;
          state_d = S_STOP1;
        end
        // Only reached with two stop bits; line stays high.
        S_STOP1: state_d = S_STOP2;
        default: ;
      endcase
    end
  end

  // State and registered outputs; reset forces an idle line at any time.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q    <= S_IDLE;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      txc_set_q  <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      txc_set_q  <= txc_set_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
    end
  end

  // Pop is same-cycle with the load so the show-ahead head word is the one
  // latched; it is gated by !fifo_empty through the load term.
  assign fifo_re = load;
  assign txd     = txd_q;
  assign busy    = busy_q;
  assign txc_set = txc_set_q;

endmodule

// File: tb/tb_usart_tx_serializer.sv
// Directed bench for usart_tx_serializer with a small show-ahead FIFO model.
module tb_usart_tx_serializer;

  logic       cp2 = 1'b0;
  logic       ireset, tx_tick, txen, usbs, fifo_empty;
  logic [2:0] ucsz;
  logic [1:0] upm;
  logic [8:0] fifo_dout;
  logic       fifo_re, txd, txc_set, busy;

  int checks = 0, errors = 0, pops = 0, txcs = 0, bad_re = 0;
  int p0, t0;
  logic [8:0] fq[$];

  always #5 cp2 = ~cp2;

  usart_tx_serializer #(.DATA_W(9)) dut (
    .cp2(cp2), .ireset(ireset), .tx_tick(tx_tick), .txen(txen),
    .ucsz(ucsz), .upm(upm), .usbs(usbs),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .txd(txd), .txc_set(txc_set), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = fifo_empty ? 9'h0 : fq[0];
  endtask

  // One cp2 cycle: drive, observe strobes mid-cycle, pop after the edge.
  task automatic step(input logic tk);
    logic re;
    tx_tick = tk;
    upd_fifo();
    @(negedge cp2);
    re = fifo_re;
    if (fifo_re) pops++;
    if (fifo_re && fifo_empty) bad_re++;
    if (txc_set) txcs++;
    @(posedge cp2);
    #1;
    if (re && fq.size() > 0) void'(fq.pop_front());
    tx_tick = 1'b0;
    upd_fifo();
  endtask

  task automatic gap();
    repeat (3) step(1'b0);
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // Ticks n bits, checking txd per tick; optional poke after tick poke_at:
  // kind 0 drops txen, 1 scrambles config, 2 flushes the FIFO.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int n,
                           input int poke_at, input int kind);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      chk($sformatf("%s_b%0d", tag, i), 32'(txd), 32'(bits[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      if (i == poke_at) begin
        case (kind)
          0: txen = 1'b0;
          1: begin ucsz = 3'b000; upm = 2'b11; usbs = 1'b1; end
          default: fq.delete();
        endcase
      end
      gap();
    end
  endtask

  task automatic end_frame(input string tag);
    step(1'b1);
    chk({tag, "_end_txd"}, 32'(txd), 32'd1);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_txc"}, 32'(txc_set), 32'd1);
    step(1'b0);
    chk({tag, "_txc_off"}, 32'(txc_set), 32'd0);
    repeat (2) step(1'b0);
  endtask

  initial begin
    ireset = 1'b0; tx_tick = 1'b0; txen = 1'b0;
    ucsz = 3'b011; upm = 2'b00; usbs = 1'b0;
    upd_fifo();
    repeat (2) step(1'b0);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_re", 32'(fifo_re), 32'd0);
    chk("rst_txc", 32'(txc_set), 32'd0);
    ireset = 1'b1;
    step(1'b0);
    txen = 1'b1;

    // 8N1 0xA5
    fq.push_back(9'h0A5); p0 = pops; t0 = txcs;
    run_frame("a5", f8n1(8'hA5), 10, -1, 0);
    end_frame("a5");
    chk("a5_pops", 32'(pops - p0), 32'd1);
    chk("a5_txcs", 32'(txcs - t0), 32'd1);

    // tick while idle with empty FIFO
    p0 = pops;
    step(1'b1);
    chk("idle_txd", 32'(txd), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pops", 32'(pops - p0), 32'd0);
    gap();

    // 5O1 0x13: 0,1,1,0,0,1,par 0,stop 1
    ucsz = 3'b000; upm = 2'b11;
    fq.push_back(9'h013);
    run_frame("5o1", 16'h00A6, 8, -1, 0);
    end_frame("5o1");

    // 5E1 0x0E0: bits above size ignored -> data 0, parity 0
    upm = 2'b10;
    fq.push_back(9'h0E0);
    run_frame("5e1", 16'h0080, 8, -1, 0);
    end_frame("5e1");

    // 9E2 0x1FF, FIFO flushed mid-frame
    ucsz = 3'b111; upm = 2'b10; usbs = 1'b1;
    fq.push_back(9'h1FF); fq.push_back(9'h0AA); p0 = pops;
    run_frame("9e2", 16'h1FFE, 13, 3, 2);
    end_frame("9e2");
    chk("9e2_pops", 32'(pops - p0), 32'd1);
    ucsz = 3'b011; upm = 2'b00; usbs = 1'b0;

    // back-to-back 8N1, config scrambled during second frame
    fq.push_back(9'h055); fq.push_back(9'h00F); p0 = pops; t0 = txcs;
    run_frame("b2b1", f8n1(8'h55), 10, -1, 0);
    run_frame("b2b2", f8n1(8'h0F), 10, 2, 1);
    end_frame("b2b");
    chk("b2b_pops", 32'(pops - p0), 32'd2);
    chk("b2b_txcs", 32'(txcs - t0), 32'd1);
    ucsz = 3'b011; upm = 2'b00; usbs = 1'b0;

    // txen dropped during 4th data bit with 2 queued
    fq.push_back(9'h033); fq.push_back(9'h0CC); p0 = pops;
    run_frame("txen", f8n1(8'h33), 10, 4, 0);
    end_frame("txen");
    chk("txen_fifo", 32'(fq.size()), 32'd1);
    repeat (2) begin step(1'b1); gap(); end
    chk("txen_pops", 32'(pops - p0), 32'd1);
    chk("txen_busy", 32'(busy), 32'd0);
    chk("txen_txd", 32'(txd), 32'd1);

    // async reset mid-DATA, then fresh frame
    txen = 1'b1;
    fq.push_back(9'h081); p0 = pops; t0 = txcs;
    repeat (3) step(1'b1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 ireset = 1'b0;
    #1;
    chk("arst_txd", 32'(txd), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) step(1'b0);
    ireset = 1'b1;
    gap();
    run_frame("post", f8n1(8'h81), 10, -1, 0);
    end_frame("post");
    chk("post_pops", 32'(pops - p0), 32'd2);
    chk("post_txcs", 32'(txcs - t0), 32'd1);

    chk("no_re_empty", 32'(bad_re), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
